// File: rtl/seq_chunk_adder_if.sv
// Valid/ready bundle for seq_chunk_adder: the master drives operands and
// accepts results, and the slave (the adder) computes them.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock, LSB first,
// with the carry between slices held in a flop so no full-width carry chain exists.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int N   = WIDTH / CHUNK;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Signed overflow: like-signed operands whose result sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [31:0]      lsb_s;
  logic [WIDTH-1:0] a_shift_s;
  logic [WIDTH-1:0] b_shift_s;
  logic [CHUNK:0]   chunk_sum_s;

  // Slice the current chunk out of the latched operands and add it with the carry flop.
  always_comb begin
    lsb_s       = {{(32-CW){1'b0}}, idx_q} * 32'(CHUNK);
    a_shift_s   = a_q >> lsb_s;
    b_shift_s   = b_q >> lsb_s;
    chunk_sum_s = {1'b0, a_shift_s[CHUNK-1:0]} + {1'b0, b_shift_s[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, c_q};
  end

  // Sequencer: accept in IDLE, one chunk per RUN cycle, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // Subtraction runs as A + ~B + ~borrow through the same adder.
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          c_d     = bus.cin ^ bus.sub;
          sum_d   = {WIDTH{1'b0}};
          idx_d   = {CW{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // sum was cleared on accept, so OR-ing each finished slice into place is exact.
        sum_d = sum_q | (WIDTH'(chunk_sum_s[CHUNK-1:0]) << lsb_s);
        c_d   = chunk_sum_s[CHUNK];
        if (idx_q == LAST_IDX) begin
          idx_d   = {CW{1'b0}};
          cout_d  = chunk_sum_s[CHUNK];
          ovf_d   = signed_ovf(a_q[MSB], b_q[MSB], chunk_sum_s[CHUNK-1]);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + CW'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State, datapath and handshake-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      c_q         <= 1'b0;
      idx_q       <= {CW{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      c_q         <= c_d;
      idx_q       <= idx_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench: three adders (CHUNK = 1, 4, 16) share one stimulus stream;
// expected {ovf, cout, sum} is queued per instance on accept and popped on handshake.
module tb_seq_chunk_adder;
  logic        clk;
  logic        rst_n;
  logic        in_valid_s;
  logic        out_ready_s;
  logic        cin_s;
  logic        sub_s;
  logic [15:0] a_s;
  logic [15:0] b_s;

  logic [2:0]  ir_s;
  logic [2:0]  ov_s;
  logic [17:0] res_s [3];
  logic [17:0] sb_q [3][$];

  int n_vec;
  int n_bad;

  seq_chunk_adder_if #(.WIDTH(16)) bus1 ();
  seq_chunk_adder_if #(.WIDTH(16)) bus4 ();
  seq_chunk_adder_if #(.WIDTH(16)) bus16 ();

  assign bus1.in_valid   = in_valid_s;
  assign bus1.a          = a_s;
  assign bus1.b          = b_s;
  assign bus1.cin        = cin_s;
  assign bus1.sub        = sub_s;
  assign bus1.out_ready  = out_ready_s;
  assign bus4.in_valid   = in_valid_s;
  assign bus4.a          = a_s;
  assign bus4.b          = b_s;
  assign bus4.cin        = cin_s;
  assign bus4.sub        = sub_s;
  assign bus4.out_ready  = out_ready_s;
  assign bus16.in_valid  = in_valid_s;
  assign bus16.a         = a_s;
  assign bus16.b         = b_s;
  assign bus16.cin       = cin_s;
  assign bus16.sub       = sub_s;
  assign bus16.out_ready = out_ready_s;

  assign ir_s     = {bus16.in_ready, bus4.in_ready, bus1.in_ready};
  assign ov_s     = {bus16.out_valid, bus4.out_valid, bus1.out_valid};
  assign res_s[0] = {bus1.ovf, bus1.cout, bus1.sum};
  assign res_s[1] = {bus4.ovf, bus4.cout, bus4.sum};
  assign res_s[2] = {bus16.ovf, bus16.cout, bus16.sum};

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: integer arithmetic, independent of chunking and of b inversion.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [16:0] r;
    int          sa;
    int          sb;
    int          sr;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!ms) begin
      r  = {1'b0, ma} + {1'b0, mb} + 17'(mc);
      sr = sa + sb + int'(mc);
    end else begin
      r  = {1'b0, ma} + {1'b0, ~mb} + 17'(!mc);
      sr = sa - sb - int'(mc);
    end
    return {((sr > 32767) || (sr < -32768)), r};
  endfunction

  task automatic scan();
    logic [17:0] e;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        sb_q[k].delete();
      end else begin
        if (ov_s[k] && out_ready_s) begin
          if (sb_q[k].size() == 0) begin
            chk($sformatf("spurious_out_valid_%0d", k), 32'(sb_q[k].size()), 32'd1);
          end else begin
            e = sb_q[k].pop_front();
            chk($sformatf("result_%0d", k), 32'(res_s[k]), 32'(e));
          end
        end
        if (in_valid_s && ir_s[k]) sb_q[k].push_back(model(a_s, b_s, cin_s, sub_s));
      end
    end
  endtask

  task automatic cycle();
    scan();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input logic rnd_ready);
    int n;
    n = 0;
    while (ir_s != 3'b111 && n < 300) begin
      if (rnd_ready) out_ready_s = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    if (ir_s != 3'b111) chk("idle_timeout", 32'(ir_s), 32'd7);
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc, input logic ts);
    a_s        = ta;
    b_s        = tb_v;
    cin_s      = tc;
    sub_s      = ts;
    in_valid_s = 1'b1;
    cycle();
    in_valid_s = 1'b0;
    a_s        = 16'($urandom);
    b_s        = 16'($urandom);
    cin_s      = 1'($urandom);
    sub_s      = 1'($urandom);
    chk("in_ready_after_accept", 32'(ir_s), 32'd0);
  endtask

  task automatic wait_done4();
    int n;
    n = 0;
    while (!ov_s[1] && n < 20) begin
      cycle();
      n++;
    end
    chk("latency", 32'(n), 32'd4);
  endtask

  task automatic dir_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic ts, input logic [17:0] exp_r);
    out_ready_s = 1'b1;
    wait_idle(1'b0);
    out_ready_s = 1'b0;
    send(ta, tb_v, tc, ts);
    wait_done4();
    chk("directed", 32'(res_s[1]), 32'(exp_r));
    out_ready_s = 1'b1;
    cycle();
    chk("in_ready_after_handshake", 32'(ir_s[1]), 32'd1);
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    in_valid_s  = 1'b0;
    out_ready_s = 1'b0;
    a_s         = 16'h0000;
    b_s         = 16'h0000;
    cin_s       = 1'b0;
    sub_s       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ir_s), 32'd7);
    chk("rst_out_valid", 32'(ov_s), 32'd0);
    for (int k = 0; k < 3; k++) chk($sformatf("rst_result_%0d", k), 32'(res_s[k]), 32'd0);
    rst_n = 1'b1;
    cycle();

    dir_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2201});
    dir_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    dir_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    dir_op(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    dir_op(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFE});

    // Backpressure: result held and new operands ignored while out_ready is low.
    out_ready_s = 1'b1;
    wait_idle(1'b0);
    out_ready_s = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done4();
    for (int i = 0; i < 3; i++) begin
      in_valid_s = 1'b1;
      a_s        = 16'($urandom);
      b_s        = 16'($urandom);
      cycle();
      chk("bp_stable", 32'(res_s[1]), 32'({1'b0, 1'b0, 16'h3333}));
      chk("bp_in_ready", 32'(ir_s[1]), 32'd0);
    end
    in_valid_s  = 1'b0;
    out_ready_s = 1'b1;
    cycle();
    chk("bp_in_ready_rise", 32'(ir_s[1]), 32'd1);
    wait_idle(1'b0);

    // Reset two cycles into RUN aborts the operation.
    send(16'hABCD, 16'h1111, 1'b1, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(ir_s), 32'd7);
    chk("midrst_out_valid", 32'(ov_s), 32'd0);
    chk("midrst_result4", 32'(res_s[1]), 32'd0);
    chk("midrst_result1", 32'(res_s[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("midrst_hold_out_valid", 32'(ov_s), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("postrst_no_out_valid", 32'(ov_s), 32'd0);
    end
    for (int k = 0; k < 3; k++) chk($sformatf("postrst_queue_%0d", k), 32'(sb_q[k].size()), 32'd0);

    // Random vectors with random consumer backpressure.
    for (int i = 0; i < 1000; i++) begin
      wait_idle(1'b1);
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    out_ready_s = 1'b1;
    wait_idle(1'b0);
    cycle();
    for (int k = 0; k < 3; k++) chk($sformatf("final_queue_%0d", k), 32'(sb_q[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
